uart_frame_sched: RTL
=====================

// Module: uart_frame_sched
// PURPOSE
//  Frame scheduler in front of the byte-level UART transmitter. Shares the serial link between two
//  requesters: FFT result words from the output FIFO (data frame) and one 32-bit status word (status frame).
//  Wraps each payload in a fixed frame, serialises 32-bit words LSB byte first, and hands bytes to the
//  transmitter over a valid/ready handshake. Frames are never interleaved.
// PARAMETERS
//  WORDS_PER_FRAME  512    data-frame payload length in 32-bit words (FFT points); range 1..1023
//  CNT_W            10     width of the word counter; must satisfy 2**CNT_W > WORDS_PER_FRAME
//  HDR0             8'hAA  first sync byte
//  HDR1             8'h55  second sync byte
// PORTS
//  clk         in   1   system clock; all logic on the rising edge
//  rst         in   1   synchronous, active-high reset
//  data_req    in   1   level: the FIFO holds at least one full frame
//  fifo_empty  in   1   FIFO empty flag
//  fifo_rd_en  out  1   one-cycle FIFO read strobe
//  fifo_dout   in   32  FIFO read data, valid 1 cycle after fifo_rd_en
//  stat_req    in   1   one-cycle pulse: send stat_word
//  stat_word   in   32  status payload, sampled on stat_req
//  stat_drop   out  1   one-cycle pulse: stat_req arrived while a status frame was still pending; ignored
//  byte_data   out  8   byte to the transmitter
//  byte_valid  out  1   byte_data is valid
//  byte_ready  in   1   transmitter accepts; a transfer occurs on byte_valid & byte_ready
//  busy        out  1   high from grant until the last trailer byte transfers
//  grant_type  out  1   0 = data frame, 1 = status frame; valid while busy
//  frame_done  out  1   one-cycle pulse in the cycle after the final transfer
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending flag cleared, last_served = status (data wins the first tie).
//  Frame: HDR0, HDR1, TYPE (8'h01 data / 8'h02 status), payload bytes, 8'h0A, 8'h0D.
//    Byte order within each word is w[7:0], w[15:8], w[23:16], w[31:24].
//  Handshake: once byte_valid rises, byte_valid and byte_data hold stable until the transfer.
//    The next byte may be presented in the cycle after the transfer. byte_ready is ignored while byte_valid=0.
//  stat_req sets the pending flag and captures stat_word. If the pending flag is already set: stat_drop=1,
//    and the captured word is unchanged. stat_req arriving in the same cycle the pending frame is granted
//    is accepted as a new request.
//  States: IDLE -> H0 -> H1 -> TYP -> (data: FETCH -> WAITD) -> BYTE(0..3) -> ... -> T0 -> T1 -> DONE -> IDLE.
//  IDLE arbitration:
//    - Only one requester asserted: grant it.
//    - Both asserted: grant the one not in last_served, then update last_served.
//    - Neither asserted: stay in IDLE.
//  Status path: TYP -> BYTE(0..3) on the captured word. The pending flag clears on grant.
//  FETCH: assert fifo_rd_en for 1 cycle when fifo_empty=0; otherwise stall in FETCH with no timeout.
//    WAITD registers fifo_dout into the shift word.
//  After BYTE3 the word counter increments:
//    - count == WORDS_PER_FRAME-1 -> T0 and the counter wraps to 0
//    - otherwise -> FETCH
//  Exactly WORDS_PER_FRAME reads per data frame. fifo_rd_en is never asserted while fifo_empty=1.
//  DONE: frame_done=1 and busy=0 for 1 cycle.
//  Reset mid-frame: the frame is abandoned with no trailer. FIFO words already read are lost.
// STRUCTURE
//  Package uart_frame_pkg: state encoding, HDR/TYPE constants, LF=8'h0A, CR=8'h0D.
//  One sub-module, uart_frame_arb: 2-way round-robin with last_served register, grant_type out.
// TESTING
//  1 Status only: stat_req, stat_word=32'h12345678, byte_ready=1 ->
//    bytes AA 55 02 78 56 34 12 0A 0D, then one frame_done pulse.
//  2 Data only, WORDS_PER_FRAME=2, FIFO holds 32'hDEADBEEF, 32'h00000001 ->
//    AA 55 01 EF BE AD DE 01 00 00 00 0A 0D; exactly 2 fifo_rd_en pulses.
//  3 data_req and stat_req in the same cycle after reset -> data frame first, then status frame.
//    Repeated ties alternate between the two.
//  4 byte_ready held 0 for 50 cycles mid-payload -> byte_valid and byte_data stay stable; no byte skipped.
//  5 fifo_empty=1 for 20 cycles mid-frame -> stall in FETCH, no rd_en asserted, frame resumes intact.
//    A second stat_req while one is pending -> stat_drop pulse.
//  6 rst asserted during BYTE2 -> all outputs 0 next cycle. A subsequent status request sends a full frame.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_pkg
//   Shared constants for the UART frame scheduler:
//   - FSM state encoding (4-bit legacy-compatible constants)
//   - frame header / type / trailer byte values
//   - grant type encoding (data vs. status frame)
//   - helper mapping a grant type onto its TYPE byte
// ---------------------------------------------------------------------------
package uart_frame_pkg;

  // FSM state encoding
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_H0    = 4'd1;
  localparam logic [3:0] ST_H1    = 4'd2;
  localparam logic [3:0] ST_TYP   = 4'd3;
  localparam logic [3:0] ST_FETCH = 4'd4;
  localparam logic [3:0] ST_WAITD = 4'd5;
  localparam logic [3:0] ST_BYTE  = 4'd6;
  localparam logic [3:0] ST_T0    = 4'd7;
  localparam logic [3:0] ST_T1    = 4'd8;
  localparam logic [3:0] ST_DONE  = 4'd9;

  // Frame byte constants
  localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
  localparam logic [7:0] HDR1_DEFAULT = 8'h55;
  localparam logic [7:0] TYPE_DATA    = 8'h01;
  localparam logic [7:0] TYPE_STAT    = 8'h02;
  localparam logic [7:0] LF           = 8'h0A;
  localparam logic [7:0] CR           = 8'h0D;

  // Which requester owns the link
  typedef enum logic {
    GT_DATA = 1'b0,
    GT_STAT = 1'b1
  } grant_type_t;

  // TYPE byte that goes out after the two sync bytes
  function automatic logic [7:0] frame_type_byte(input logic gt);
    return (gt == GT_STAT) ? TYPE_STAT : TYPE_DATA;
  endfunction

endpackage

// File: rtl/uart_frame_sched_if.sv
// ---------------------------------------------------------------------------
// uart_frame_sched_if
//   Byte stream between the frame scheduler and the byte-level UART
//   transmitter. A transfer happens on byte_valid & byte_ready.
//   master : scheduler side  (drives byte_data, byte_valid; reads byte_ready)
//   slave  : transmitter side (reads byte_data, byte_valid; drives byte_ready)
// ---------------------------------------------------------------------------
interface uart_frame_sched_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/uart_frame_arb.sv
// ---------------------------------------------------------------------------
// uart_frame_arb
//   Two-way round-robin arbiter between the data and status requesters.
//   Ports:
//     clk, rst    clock / synchronous active-high reset
//     en          arbitration allowed this cycle (scheduler idle)
//     req_data    data frame requested
//     req_stat    status frame requested
//     grant       a requester is granted this cycle (combinational)
//     grant_type  0 = data, 1 = status (combinational, valid with grant)
//   last_served resets to "status" so that data wins the first tie.
// ---------------------------------------------------------------------------
module uart_frame_arb
  import uart_frame_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_data,
  input  logic req_stat,
  output logic grant,
  output logic grant_type
);

  logic last_served_reg;

  always_comb begin
    grant      = 1'b0;
    grant_type = GT_DATA;
    if (en) begin
      if (req_data && req_stat) begin
        grant      = 1'b1;
        // Serve whichever side was not served last
        grant_type = ~last_served_reg;
      end else if (req_data) begin
        grant      = 1'b1;
        grant_type = GT_DATA;
      end else if (req_stat) begin
        grant      = 1'b1;
        grant_type = GT_STAT;
      end
    end
  end

  // Every grant updates the history, so a requester that was just served
  // alone still yields the next tie to the other side.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_served_reg <= GT_STAT;
    end else if (grant) begin
      last_served_reg <= grant_type;
    end
  end

endmodule

// File: rtl/uart_frame_sched.sv
// ---------------------------------------------------------------------------
// uart_frame_sched
//   Frame scheduler in front of the byte-level UART transmitter. Shares the
//   link between FFT result words (data frame, WORDS_PER_FRAME words read
//   from a FIFO) and a single 32-bit status word (status frame). Frame:
//     HDR0 HDR1 TYPE payload(LSB byte first per word) LF CR
//   Frames are never interleaved.
//   Ports:
//     clk, rst     clock / synchronous active-high reset
//     data_req     FIFO holds at least one full frame (level)
//     fifo_empty   FIFO empty flag
//     fifo_rd_en   one-cycle FIFO read strobe
//     fifo_dout    FIFO data, valid the cycle after fifo_rd_en
//     stat_req     one-cycle pulse: send stat_word
//     stat_word    status payload, captured on an accepted stat_req
//     stat_drop    pulse: stat_req ignored because one was still pending
//     tx           byte stream to the transmitter (master modport)
//     busy         high from grant until the last trailer byte transfers
//     grant_type   0 = data frame, 1 = status frame; valid while busy
//     frame_done   pulse in the cycle after the final transfer
// ---------------------------------------------------------------------------
module uart_frame_sched
  import uart_frame_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = 512,
  parameter int unsigned CNT_W           = 10,
  parameter logic [7:0]  HDR0            = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1            = HDR1_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_req,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [31:0]          fifo_dout,
  input  logic                 stat_req,
  input  logic [31:0]          stat_word,
  output logic                 stat_drop,
  uart_frame_sched_if.master   tx,
  output logic                 busy,
  output logic                 grant_type,
  output logic                 frame_done
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_FRAME - 1);

  // State registers
  logic [3:0]       state_reg,      state_next;
  logic [1:0]       byte_idx_reg,   byte_idx_next;
  logic [CNT_W-1:0] word_cnt_reg,   word_cnt_next;
  logic [31:0]      shift_reg,      shift_next;
  logic             grant_type_reg, grant_type_next;

  // Status request bookkeeping
  logic             pending_reg,    pending_next;
  logic [31:0]      stat_word_reg,  stat_word_next;
  logic             stat_drop_reg,  stat_drop_next;

  // Arbiter
  logic arb_grant;
  logic arb_type;
  logic grant_stat;
  logic pend_hold;

  // Byte stream
  logic       xfer;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] lane [4];

  uart_frame_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (state_reg == ST_IDLE),
    .req_data   (data_req),
    .req_stat   (pending_reg),
    .grant      (arb_grant),
    .grant_type (arb_type)
  );

  // Byte lanes of the current word, LSB byte first
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = shift_reg[gi*8 +: 8];
  end

  assign xfer = out_valid & tx.byte_ready;

  // ---------------------------------------------------------------------
  // Status pending flag. A grant of the pending frame frees the slot in
  // the same cycle, so a coincident stat_req is accepted, not dropped.
  // ---------------------------------------------------------------------
  assign grant_stat = arb_grant & (arb_type == GT_STAT);
  assign pend_hold  = pending_reg & ~grant_stat;

  always_comb begin
    pending_next   = pend_hold | stat_req;
    stat_drop_next = stat_req & pend_hold;
    stat_word_next = stat_word_reg;
    if (stat_req && !pend_hold) begin
      stat_word_next = stat_word;
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    byte_idx_next   = byte_idx_reg;
    word_cnt_next   = word_cnt_reg;
    shift_next      = shift_reg;
    grant_type_next = grant_type_reg;

    case (state_reg)
      ST_IDLE: begin
        if (arb_grant) begin
          state_next      = ST_H0;
          grant_type_next = arb_type;
          byte_idx_next   = 2'd0;
          word_cnt_next   = '0;
          // Latch the status word at grant so a new request accepted in
          // this same cycle cannot alter the frame being sent.
          if (arb_type == GT_STAT) begin
            shift_next = stat_word_reg;
          end
        end
      end

      ST_H0: if (xfer) state_next = ST_H1;
      ST_H1: if (xfer) state_next = ST_TYP;

      ST_TYP: begin
        if (xfer) begin
          byte_idx_next = 2'd0;
          state_next    = (grant_type_reg == GT_STAT) ? ST_BYTE : ST_FETCH;
        end
      end

      // Waits indefinitely for the FIFO; the read strobe is gated by empty
      ST_FETCH: if (!fifo_empty) state_next = ST_WAITD;

      ST_WAITD: begin
        shift_next    = fifo_dout;
        byte_idx_next = 2'd0;
        state_next    = ST_BYTE;
      end

      ST_BYTE: begin
        if (xfer) begin
          if (byte_idx_reg == 2'd3) begin
            byte_idx_next = 2'd0;
            if (grant_type_reg == GT_STAT) begin
              state_next = ST_T0;
            end else if (word_cnt_reg == LAST_WORD) begin
              word_cnt_next = '0;
              state_next    = ST_T0;
            end else begin
              word_cnt_next = word_cnt_reg + CNT_W'(1);
              state_next    = ST_FETCH;
            end
          end else begin
            byte_idx_next = byte_idx_reg + 2'd1;
          end
        end
      end

      ST_T0:   if (xfer) state_next = ST_T1;
      ST_T1:   if (xfer) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      byte_idx_reg   <= 2'd0;
      word_cnt_reg   <= '0;
      shift_reg      <= 32'h0;
      grant_type_reg <= GT_DATA;
      pending_reg    <= 1'b0;
      stat_word_reg  <= 32'h0;
      stat_drop_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_idx_reg   <= byte_idx_next;
      word_cnt_reg   <= word_cnt_next;
      shift_reg      <= shift_next;
      grant_type_reg <= grant_type_next;
      pending_reg    <= pending_next;
      stat_word_reg  <= stat_word_next;
      stat_drop_reg  <= stat_drop_next;
    end
  end

  // ---------------------------------------------------------------------
  // Byte output. Derived only from registered state, so valid and data
  // stay stable until the state advances on a transfer.
  // ---------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b1;
    out_data  = 8'h00;
    case (state_reg)
      ST_H0:   out_data = HDR0;
      ST_H1:   out_data = HDR1;
      ST_TYP:  out_data = frame_type_byte(grant_type_reg);
      ST_BYTE: out_data = lane[byte_idx_reg];
      ST_T0:   out_data = LF;
      ST_T1:   out_data = CR;
      default: out_valid = 1'b0;
    endcase
  end

  assign tx.byte_valid = out_valid;
  assign tx.byte_data  = out_data;

  assign fifo_rd_en = (state_reg == ST_FETCH) & ~fifo_empty;
  assign busy       = (state_reg != ST_IDLE) & (state_reg != ST_DONE);
  assign frame_done = (state_reg == ST_DONE);
  assign grant_type = grant_type_reg;
  assign stat_drop  = stat_drop_reg;

endmodule
